// File: rtl/game_controller.sv
// Guessing-game controller: coin-to-credit accounting plus the IDLE/LOAD/PLAY/WIN/LOSE
// sequencing that loads a master pattern and grades up to MAX_ROUNDS guesses against it.
module game_controller #(
    parameter int MAX_ROUNDS = 8,
    parameter int GAME_COST  = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       CoinInserted,
    input  logic [1:0] CoinValue,
    input  logic       StartGame,
    input  logic       masterLoaded,
    input  logic       GradeIt,
    input  logic [3:0] Znarly,
    input  logic [3:0] Zood,
    output logic       loadingShape,
    output logic       clearMaster,
    output logic [2:0] NumGames,
    output logic [3:0] RoundNumber,
    output logic [3:0] ZnarlyOut,
    output logic [3:0] ZoodOut,
    output logic       GradeValid,
    output logic       GameWon,
    output logic       GameLost
);

    typedef enum logic [2:0] {IDLE, LOAD, PLAY, WIN, LOSE} stateT;

    localparam logic [7:0] COST       = 8'(GAME_COST);
    localparam logic [3:0] LAST_ROUND = 4'(MAX_ROUNDS);

    stateT      state, nextState;
    logic [7:0] coinAcc, nextAcc, coinSum;
    logic [2:0] nextGames;
    logic [3:0] nextRound, nextZn, nextZo;
    logic       nextGv, nextWon, nextLost, nextClear;
    logic       creditIn, creditOut;

    // Coins are accepted in every state; a full credit bank freezes the accumulator too.
    always_comb begin
        nextAcc  = coinAcc;
        creditIn = 1'b0;
        coinSum  = coinAcc + {6'd0, CoinValue};
        if (CoinInserted && CoinValue != 2'b00 && NumGames != 3'd7) begin
            if (coinSum >= COST) begin
                creditIn = 1'b1;
                nextAcc  = coinSum - COST;
            end else begin
                nextAcc = coinSum;
            end
        end
    end

    always_comb begin
        nextState = state;
        nextRound = RoundNumber;
        nextZn    = ZnarlyOut;
        nextZo    = ZoodOut;
        nextGv    = 1'b0;
        nextWon   = GameWon;
        nextLost  = GameLost;
        nextClear = 1'b0;
        creditOut = 1'b0;
        case (state)
            IDLE, WIN, LOSE: begin
                // Starting a game also clears the round counter, since no game is active yet.
                if (StartGame && NumGames != 3'd0) begin
                    nextState = LOAD;
                    creditOut = 1'b1;
                    nextClear = 1'b1;
                    nextWon   = 1'b0;
                    nextLost  = 1'b0;
                    nextZn    = 4'd0;
                    nextZo    = 4'd0;
                    nextRound = 4'd0;
                end
            end
            LOAD: begin
                if (masterLoaded) begin
                    nextState = PLAY;
                    nextRound = 4'd1;
                end
            end
            PLAY: begin
                if (GradeIt) begin
                    nextZn = Znarly;
                    nextZo = Zood;
                    nextGv = 1'b1;
                    if (Znarly >= 4'd4) begin
                        nextState = WIN;
                        nextWon   = 1'b1;
                    end else if (RoundNumber == LAST_ROUND) begin
                        nextState = LOSE;
                        nextLost  = 1'b1;
                    end else begin
                        nextRound = RoundNumber + 4'd1;
                    end
                end
            end
            default: nextState = IDLE;
        endcase
    end

    assign nextGames    = NumGames + {2'b00, creditIn} - {2'b00, creditOut};
    assign loadingShape = (state == LOAD);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            coinAcc     <= 8'd0;
            NumGames    <= 3'd0;
            RoundNumber <= 4'd0;
            ZnarlyOut   <= 4'd0;
            ZoodOut     <= 4'd0;
            GradeValid  <= 1'b0;
            GameWon     <= 1'b0;
            GameLost    <= 1'b0;
            clearMaster <= 1'b0;
        end else begin
            state       <= nextState;
            coinAcc     <= nextAcc;
            NumGames    <= nextGames;
            RoundNumber <= nextRound;
            ZnarlyOut   <= nextZn;
            ZoodOut     <= nextZo;
            GradeValid  <= nextGv;
            GameWon     <= nextWon;
            GameLost    <= nextLost;
            clearMaster <= nextClear;
        end
    end

endmodule

// File: tb/tb_game_controller.sv
// Self-checking bench for game_controller: directed scenarios followed by random traffic,
// all compared against a cycle-level behavioural model of the game rules.
module tb_game_controller;

    localparam int MAX_ROUNDS = 8;
    localparam int GAME_COST  = 4;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       CoinInserted = 1'b0;
    logic [1:0] CoinValue = 2'b00;
    logic       StartGame = 1'b0;
    logic       masterLoaded = 1'b0;
    logic       GradeIt = 1'b0;
    logic [3:0] Znarly = 4'd0;
    logic [3:0] Zood = 4'd0;
    logic       loadingShape, clearMaster, GradeValid, GameWon, GameLost;
    logic [2:0] NumGames;
    logic [3:0] RoundNumber, ZnarlyOut, ZoodOut;

    int testCount = 0;
    int failCount = 0;

    typedef enum {M_IDLE, M_LOAD, M_PLAY, M_OVER} phaseT;
    phaseT mPhase;
    int    mCredits, mAcc, mRound, mZn, mZo;
    bit    mGv, mWon, mLost, mClear;

    game_controller #(.MAX_ROUNDS(MAX_ROUNDS), .GAME_COST(GAME_COST)) dut (
        .clock(clock), .reset(reset), .CoinInserted(CoinInserted), .CoinValue(CoinValue),
        .StartGame(StartGame), .masterLoaded(masterLoaded), .GradeIt(GradeIt),
        .Znarly(Znarly), .Zood(Zood), .loadingShape(loadingShape), .clearMaster(clearMaster),
        .NumGames(NumGames), .RoundNumber(RoundNumber), .ZnarlyOut(ZnarlyOut),
        .ZoodOut(ZoodOut), .GradeValid(GradeValid), .GameWon(GameWon), .GameLost(GameLost)
    );

    always #5 clock = ~clock;

    task automatic resetModel();
        mPhase = M_IDLE;
        mCredits = 0; mAcc = 0; mRound = 0; mZn = 0; mZo = 0;
        mGv = 0; mWon = 0; mLost = 0; mClear = 0;
    endtask

    // One clock of game rules, evaluated on the inputs present before the edge.
    task automatic modelStep();
        int credit = 0;
        int take = 0;
        mGv = 0;
        mClear = 0;
        if (CoinInserted && CoinValue != 0 && mCredits < 7) begin
            mAcc += int'(CoinValue);
            if (mAcc >= GAME_COST) begin
                credit = 1;
                mAcc -= GAME_COST;
            end
        end
        case (mPhase)
            M_IDLE, M_OVER: if (StartGame && mCredits > 0) begin
                take = 1; mPhase = M_LOAD; mClear = 1;
                mWon = 0; mLost = 0; mZn = 0; mZo = 0; mRound = 0;
            end
            M_LOAD: if (masterLoaded) begin
                mPhase = M_PLAY; mRound = 1;
            end
            M_PLAY: if (GradeIt) begin
                mZn = int'(Znarly); mZo = int'(Zood); mGv = 1;
                if (mZn >= 4) begin
                    mWon = 1; mPhase = M_OVER;
                end else if (mRound == MAX_ROUNDS) begin
                    mLost = 1; mPhase = M_OVER;
                end else begin
                    mRound++;
                end
            end
            default: ;
        endcase
        mCredits += credit - take;
    endtask

    task automatic checkField(input string name, input logic [31:0] observed, input logic [31:0] expected);
        testCount++;
        assert (observed === expected) else begin
            failCount++;
            $error("[TB] FAIL %s: got %0d, expected %0d", name, observed, expected);
        end
    endtask

    task automatic checkOutput(input string tag);
        checkField({tag, ".NumGames"}, 32'(NumGames), 32'(mCredits));
        checkField({tag, ".RoundNumber"}, 32'(RoundNumber), 32'(mRound));
        checkField({tag, ".ZnarlyOut"}, 32'(ZnarlyOut), 32'(mZn));
        checkField({tag, ".ZoodOut"}, 32'(ZoodOut), 32'(mZo));
        checkField({tag, ".GradeValid"}, 32'(GradeValid), 32'(mGv));
        checkField({tag, ".GameWon"}, 32'(GameWon), 32'(mWon));
        checkField({tag, ".GameLost"}, 32'(GameLost), 32'(mLost));
        checkField({tag, ".loadingShape"}, 32'(loadingShape), 32'(mPhase == M_LOAD));
        checkField({tag, ".clearMaster"}, 32'(clearMaster), 32'(mClear));
    endtask

    task automatic applyStimulus(input logic coin, input logic [1:0] cval, input logic start,
                                 input logic loaded, input logic grade, input logic [3:0] zn,
                                 input logic [3:0] zo, input string tag);
        CoinInserted = coin; CoinValue = cval; StartGame = start;
        masterLoaded = loaded; GradeIt = grade; Znarly = zn; Zood = zo;
        @(posedge clock);
        modelStep();
        #1;
        checkOutput(tag);
    endtask

    initial begin
        reset = 1'b1;
        resetModel();
        #12;
        reset = 1'b0;
        checkOutput("reset");

        applyStimulus(0, 2'd0, 1, 0, 0, 0, 0, "startNoCredit");
        checkField("startNoCredit.clear", 32'(clearMaster), 0);
        applyStimulus(1, 2'd3, 0, 0, 0, 0, 0, "coin3");
        applyStimulus(1, 2'd1, 0, 0, 0, 0, 0, "coin1");
        checkField("coins31.NumGames", 32'(NumGames), 1);
        applyStimulus(1, 2'd0, 0, 0, 0, 0, 0, "coinInvalid");
        applyStimulus(1, 2'd2, 0, 0, 0, 0, 0, "coin2a");
        applyStimulus(1, 2'd2, 0, 0, 0, 0, 0, "coin2b");
        checkField("coins22.NumGames", 32'(NumGames), 2);
        repeat (8) applyStimulus(1, 2'd3, 0, 0, 0, 0, 0, "fill");
        applyStimulus(1, 2'd3, 0, 0, 0, 0, 0, "coinAtMax");
        checkField("coinAtMax.NumGames", 32'(NumGames), 7);

        applyStimulus(0, 2'd0, 1, 0, 0, 0, 0, "start");
        checkField("start.loading", 32'(loadingShape), 1);
        applyStimulus(0, 2'd0, 1, 0, 0, 0, 0, "startInLoad");
        applyStimulus(0, 2'd0, 0, 1, 0, 0, 0, "loaded");
        checkField("loaded.round", 32'(RoundNumber), 1);
        applyStimulus(0, 2'd0, 0, 0, 1, 4'd2, 4'd1, "grade21");
        checkField("grade21.round", 32'(RoundNumber), 2);
        applyStimulus(0, 2'd0, 1, 0, 0, 0, 0, "startInPlay");
        applyStimulus(0, 2'd0, 0, 0, 1, 4'd4, 4'd0, "gradeWin");
        checkField("gradeWin.won", 32'(GameWon), 1);
        applyStimulus(0, 2'd0, 0, 0, 1, 4'd1, 4'd1, "gradeInWin");

        applyStimulus(1, 2'd3, 1, 0, 0, 0, 0, "restartWithCoin");
        applyStimulus(0, 2'd0, 0, 1, 0, 0, 0, "load2");
        for (int i = 0; i < MAX_ROUNDS; i++) applyStimulus(0, 2'd0, 0, 0, 1, 4'd3, 4'd1, "gradeLose");
        checkField("lose.lost", 32'(GameLost), 1);
        checkField("lose.round", 32'(RoundNumber), MAX_ROUNDS);
        applyStimulus(0, 2'd0, 0, 0, 1, 4'd3, 4'd1, "ninthGrade");
        checkField("ninthGrade.gv", 32'(GradeValid), 0);

        while (mCredits > 0) begin
            applyStimulus(0, 2'd0, 1, 0, 0, 0, 0, "drain");
            applyStimulus(0, 2'd0, 0, 1, 0, 0, 0, "drainLoad");
            applyStimulus(0, 2'd0, 0, 0, 1, 4'd4, 4'd2, "drainWin");
        end
        applyStimulus(1, 2'd2, 0, 0, 0, 0, 0, "c1");
        applyStimulus(1, 2'd2, 0, 0, 0, 0, 0, "c2");
        applyStimulus(0, 2'd0, 1, 0, 0, 0, 0, "lastStart");
        applyStimulus(0, 2'd0, 0, 1, 0, 0, 0, "lastLoad");
        applyStimulus(0, 2'd0, 0, 0, 1, 4'd1, 4'd2, "lastGrade");
        #2;
        reset = 1'b1;
        #1;
        resetModel();
        checkOutput("asyncReset");
        checkField("asyncReset.round", 32'(RoundNumber), 0);
        #3;
        reset = 1'b0;
        applyStimulus(0, 2'd0, 1, 0, 0, 0, 0, "startAfterReset");
        checkField("startAfterReset.clear", 32'(clearMaster), 0);

        repeat (3000) begin
            applyStimulus(($urandom_range(0, 2) == 0), 2'($urandom_range(0, 3)),
                          ($urandom_range(0, 7) == 0), ($urandom_range(0, 3) == 0),
                          ($urandom_range(0, 2) == 0), 4'($urandom_range(0, 4)),
                          4'($urandom_range(0, 4)), "rand");
        end

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
